// File: rtl/pipelined_carry_select_adder.sv
// rtl/pipelined_carry_select_adder.sv - pipelined carry-select adder/subtractor with valid/ready stream
//
// Purpose: adds x + y + carryin (sub=0) or computes x - y (sub=1) over N bits.
// The datapath is cut into STAGES slices of N/STAGES bits; slice k is resolved
// in pipeline stage k using BLOCK-bit carry-select blocks, and its carry-out is
// registered into the next stage. One beat per cycle, latency STAGES cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all valid/data/carry state
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (low only while the output is stalled)
//   x, y       N-bit operands
//   carryin    carry-in for add; ignored when sub=1
//   sub        0: x + y + carryin, 1: x - y
//   out_valid  result beat valid
//   out_ready  consumer accepts the result this cycle
//   sum        N-bit result
//   carryout   carry out of bit N-1 (no-borrow flag when sub=1)
//   overflow   two's-complement overflow

module pipelined_carry_select_adder #(
    parameter int N      = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         carryin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carryout,
    output logic         overflow
);

    localparam int SW   = N / STAGES;
    localparam int NBLK = SW / BLOCK;

    logic [N-1:0] ye;
    logic         ce;
    logic         stall;
    logic         advance;

    always_comb begin
        ye = sub ? ~y : y;
        ce = sub | carryin;
    end

    // One global stall: the whole pipe freezes while the result is refused.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int HI = LO + SW;
        // Register layout: [W-1:N] remaining ye bits, [N-1:HI] remaining x bits,
        // [HI-1:0] finished sum bits. The last stage keeps only the sum.
        localparam int W  = 2 * N - HI;

        logic [N-1:LO] src_x;
        logic [N-1:LO] src_ye;
        logic          src_c;
        logic          src_v;
        logic          src_xs;
        logic          src_ys;
        logic [SW-1:0] s_sl;
        logic          c_sl;
        logic [HI-1:0] sum_lo_d;
        logic [W-1:0]  data_d;
        logic [W-1:0]  data_q;
        logic          valid_d;
        logic          valid_q;
        logic          carry_d;
        logic          carry_q;

        if (k == 0) begin : g_first
            assign src_x    = x;
            assign src_ye   = ye;
            assign src_c    = ce;
            assign src_v    = in_valid & in_ready;
            assign src_xs   = x[N-1];
            assign src_ys   = ye[N-1];
            assign sum_lo_d = s_sl;
        end else begin : g_next
            assign src_x    = g_stage[k-1].data_q[N-1:LO];
            assign src_ye   = g_stage[k-1].data_q[2*N-LO-1:N];
            assign src_c    = g_stage[k-1].carry_q;
            assign src_v    = g_stage[k-1].valid_q;
            assign src_xs   = g_stage[k-1].g_mid.xs_q;
            assign src_ys   = g_stage[k-1].g_mid.ys_q;
            assign sum_lo_d = {s_sl, g_stage[k-1].data_q[LO-1:0]};
        end

        // Each block precomputes both carry-in cases; the rippling block carry
        // only drives the select, so the slice path is one adder plus NBLK muxes.
        always_comb begin : csel
            logic [BLOCK:0] r0;
            logic [BLOCK:0] r1;
            logic           c;
            r0   = '0;
            r1   = '0;
            c    = src_c;
            s_sl = '0;
            for (int j = 0; j < NBLK; j++) begin
                r0 = {1'b0, src_x[LO+j*BLOCK +: BLOCK]} + {1'b0, src_ye[LO+j*BLOCK +: BLOCK]};
                r1 = {1'b0, src_x[LO+j*BLOCK +: BLOCK]} + {1'b0, src_ye[LO+j*BLOCK +: BLOCK]}
                     + {{BLOCK{1'b0}}, 1'b1};
                s_sl[j*BLOCK +: BLOCK] = c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
                c = c ? r1[BLOCK] : r0[BLOCK];
            end
            c_sl = c;
        end

        always_comb begin
            valid_d = src_v;
            carry_d = c_sl;
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_d;
            logic ovf_q;

            // s_sl[SW-1] is the final sum sign bit.
            always_comb begin
                data_d = sum_lo_d;
                ovf_d  = (src_xs ^ s_sl[SW-1]) & (src_ys ^ s_sl[SW-1]);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end else begin : g_mid
            logic xs_d;
            logic xs_q;
            logic ys_d;
            logic ys_q;

            always_comb begin
                data_d = {src_ye[N-1:HI], src_x[N-1:HI], sum_lo_d};
                xs_d   = src_xs;
                ys_d   = src_ys;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xs_q <= 1'b0;
                    ys_q <= 1'b0;
                end else if (advance) begin
                    xs_q <= xs_d;
                    ys_q <= ys_d;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                data_q  <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                data_q  <= data_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].data_q;
    assign carryout  = g_stage[STAGES-1].carry_q;
    assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb/tb_pipelined_carry_select_adder.sv - self-checking bench for pipelined_carry_select_adder
module tb_pipelined_carry_select_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, carryin, sub, out_valid, out_ready, carryout, overflow;
    logic [31:0] x, y, sum;

    logic        sw_in_valid, sw_out_ready, sw_cin, sw_sub;
    logic [63:0] sw_x, sw_y;
    logic        a_in_ready, a_out_valid, a_co, a_ov;
    logic [15:0] a_sum;
    logic        b_in_ready, b_out_valid, b_co, b_ov;
    logic [63:0] b_sum;

    int checks   = 0;
    int failures = 0;

    pipelined_carry_select_adder #(.N(32), .BLOCK(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .carryin(carryin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carryout(carryout), .overflow(overflow)
    );

    pipelined_carry_select_adder #(.N(16), .BLOCK(4), .STAGES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(a_in_ready),
        .x(sw_x[15:0]), .y(sw_y[15:0]), .carryin(sw_cin), .sub(sw_sub),
        .out_valid(a_out_valid), .out_ready(sw_out_ready),
        .sum(a_sum), .carryout(a_co), .overflow(a_ov)
    );

    pipelined_carry_select_adder #(.N(64), .BLOCK(8), .STAGES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(b_in_ready),
        .x(sw_x), .y(sw_y), .carryin(sw_cin), .sub(sw_sub),
        .out_valid(b_out_valid), .out_ready(sw_out_ready),
        .sum(b_sum), .carryout(b_co), .overflow(b_ov)
    );

    // Reference: exact integer arithmetic. Returns {overflow, carryout, sum}.
    function automatic logic [65:0] golden(input int n, input logic [63:0] a, input logic [63:0] b,
                                           input logic ci, input logic sb);
        logic [64:0]        mask, ua, ub, tot;
        logic signed [67:0] sa, sbv, sv, lim;
        mask = (65'd1 << n) - 65'd1;
        ua   = {1'b0, a} & mask;
        ub   = {1'b0, b} & mask;
        if (sb) tot = ua + ((65'd1 << n) - ub);
        else    tot = ua + ub + {64'd0, ci};
        sa  = $signed({3'b000, ua});
        if (ua[n-1]) sa = sa - (68'sd1 <<< n);
        sbv = $signed({3'b000, ub});
        if (ub[n-1]) sbv = sbv - (68'sd1 <<< n);
        sv  = sb ? (sa - sbv) : (sa + sbv + $signed({67'd0, ci}));
        lim = 68'sd1 <<< (n - 1);
        return {((sv >= lim) || (sv < -lim)), tot[n], tot[63:0] & mask[63:0]};
    endfunction

    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                            output logic [31:0] so, output logic co, output logic ov, output int lat);
        @(negedge clk);
        x = a; y = b; carryin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; so = '0; co = 1'b0; ov = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                so = sum; co = carryout; ov = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; carryin = 1'b0; sub = 1'b0;
        sw_in_valid = 1'b0; sw_out_ready = 1'b0; sw_x = '0; sw_y = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, carryout, overflow, sum} !== 35'd0)
            begin failures++; $display("FAIL reset_outputs got v=%b co=%b ov=%b sum=%h want all 0", out_valid, carryout, overflow, sum); end
        checks++;
        if (in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b0011)
            begin failures++; $display("FAIL reset_sweep_duts got %b want 0011", {a_out_valid, b_out_valid, a_in_ready, b_in_ready}); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [31:0] ax[3], ay[3], es[3];
        logic        ac[3], eco[3], eov[3];
        logic [31:0] so;
        logic        co, ov;
        int          lat;
        ax  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
        ay  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
        ac  = '{1'b0, 1'b0, 1'b1};
        es  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
        eco = '{1'b1, 1'b0, 1'b0};
        eov = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_beat(ax[i], ay[i], ac[i], 1'b0, so, co, ov, lat);
            checks++;
            if ({ov, co, so} !== {eov[i], eco[i], es[i]})
                begin failures++; $display("FAIL add_%0d got ov=%b co=%b sum=%h want ov=%b co=%b sum=%h", i, ov, co, so, eov[i], eco[i], es[i]); end
            checks++;
            if (lat !== 2)
                begin failures++; $display("FAIL add_latency_%0d got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_sub();
        logic [31:0] ax[4], ay[4], es[4];
        logic        ac[4], eco[4], eov[4];
        logic [31:0] so;
        logic        co, ov;
        int          lat;
        ax  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        ay  = '{32'd7, 32'd7, 32'h0000_0001, 32'h0000_0001};
        ac  = '{1'b0, 1'b1, 1'b0, 1'b1};
        es  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        eco = '{1'b0, 1'b0, 1'b1, 1'b1};
        eov = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_beat(ax[i], ay[i], ac[i], 1'b1, so, co, ov, lat);
            checks++;
            if ({ov, co, so} !== {eov[i], eco[i], es[i]})
                begin failures++; $display("FAIL sub_%0d got ov=%b co=%b sum=%h want ov=%b co=%b sum=%h", i, ov, co, so, eov[i], eco[i], es[i]); end
            checks++;
            if (lat !== 2)
                begin failures++; $display("FAIL sub_latency_%0d got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_random_single();
        logic [31:0] a, b, so;
        logic        c, s, co, ov;
        logic [65:0] e;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            if (i < 4) b = a;
            e = golden(32, {32'd0, a}, {32'd0, b}, c, s);
            run_beat(a, b, c, s, so, co, ov, lat);
            checks++;
            if ({ov, co, so} !== {e[65], e[64], e[31:0]} || lat !== 2)
                begin failures++; $display("FAIL random_%0d got ov=%b co=%b sum=%h lat=%0d want ov=%b co=%b sum=%h lat=2", i, ov, co, so, lat, e[65], e[64], e[31:0]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [65:0] q[$];
        logic [65:0] e;
        logic [31:0] held;
        logic        held_v   = 1'b0;
        logic        need_new = 1'b1;
        int          sent = 0, got = 0, cyc = 0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 8);
            if (in_valid && need_new) begin
                x = $urandom; y = $urandom; carryin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end
            #1;
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== held)
                    begin failures++; $display("FAIL bp_hold cyc=%0d got v=%b sum=%h want v=1 sum=%h", cyc, out_valid, sum, held); end
            end
            if (!out_ready) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0)
                    begin failures++; $display("FAIL bp_stall cyc=%0d got out_valid=%b in_ready=%b want 1 0", cyc, out_valid, in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL bp_extra cyc=%0d got unexpected beat sum=%h want none", cyc, sum);
                end else begin
                    e = q.pop_front();
                    if ({overflow, carryout, sum} !== {e[65], e[64], e[31:0]})
                        begin failures++; $display("FAIL bp_data beat=%0d got ov=%b co=%b sum=%h want ov=%b co=%b sum=%h", got, overflow, carryout, sum, e[65], e[64], e[31:0]); end
                end
                got++;
            end
            held_v = out_valid && !out_ready;
            held   = sum;
            need_new = in_valid && in_ready;
            if (need_new) begin
                q.push_back(golden(32, {32'd0, x}, {32'd0, y}, carryin, sub));
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 8 || sent !== 8)
            begin failures++; $display("FAIL bp_count got %0d results %0d sent want 8 8", got, sent); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0)
                begin failures++; $display("FAIL bp_dup cyc=%0d got out_valid=%b want 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] so;
        logic        co, ov;
        int          lat;
        @(negedge clk);
        x = 32'h0000_1111; y = 32'h0000_2222; carryin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        x = 32'h0000_3333; y = 32'h0000_4444;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h0000_3333)
            begin failures++; $display("FAIL rst_mid_pre got v=%b sum=%h want v=1 sum=00003333", out_valid, sum); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, carryout, overflow, sum} !== 35'd0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL rst_mid_async got v=%b co=%b ov=%b sum=%h rdy=%b want 0 0 0 0 1", out_valid, carryout, overflow, sum, in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0)
                begin failures++; $display("FAIL rst_mid_stale cyc=%0d got out_valid=%b want 0", i, out_valid); end
        end
        run_beat(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, so, co, ov, lat);
        checks++;
        if (so !== 32'h2345_6789 || lat !== 2)
            begin failures++; $display("FAIL rst_mid_fresh got sum=%h lat=%0d want sum=23456789 lat=2", so, lat); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0)
                begin failures++; $display("FAIL rst_mid_after cyc=%0d got out_valid=%b want 0", i, out_valid); end
        end
    endtask

    task automatic test_sweep();
        logic [65:0] qa[$], qb[$];
        int          qa_acc[$], qa_st[$], qb_acc[$], qb_st[$];
        logic [65:0] e;
        int          cyc = 0, a_done = 0, b_done = 0, a_acc = 0, b_acc = 0;
        int          a_stalls = 0, b_stalls = 0, lat, exl;
        logic        feeding;
        while (cyc < 60000) begin
            feeding = (a_acc < 10000 || b_acc < 10000);
            if (!feeding && qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
            sw_in_valid  = feeding && ($urandom_range(0, 9) != 0);
            sw_out_ready = !feeding || ($urandom_range(0, 3) != 0);
            sw_x = {$urandom, $urandom}; sw_y = {$urandom, $urandom};
            sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (a_in_ready !== !(a_out_valid && !sw_out_ready) || b_in_ready !== !(b_out_valid && !sw_out_ready))
                begin failures++; $display("FAIL sweep_ready cyc=%0d got a=%b b=%b", cyc, a_in_ready, b_in_ready); end
            if (a_out_valid && sw_out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++; $display("FAIL sweep16_extra cyc=%0d got sum=%h want none", cyc, a_sum);
                end else begin
                    e   = qa.pop_front();
                    lat = cyc - qa_acc.pop_front();
                    exl = 4 + (a_stalls - qa_st.pop_front());
                    if ({a_ov, a_co, a_sum} !== {e[65], e[64], e[15:0]} || lat !== exl)
                        begin failures++; $display("FAIL sweep16 beat=%0d got ov=%b co=%b sum=%h lat=%0d want ov=%b co=%b sum=%h lat=%0d", a_done, a_ov, a_co, a_sum, lat, e[65], e[64], e[15:0], exl); end
                end
                a_done++;
            end
            if (b_out_valid && sw_out_ready) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++; $display("FAIL sweep64_extra cyc=%0d got sum=%h want none", cyc, b_sum);
                end else begin
                    e   = qb.pop_front();
                    lat = cyc - qb_acc.pop_front();
                    exl = 1 + (b_stalls - qb_st.pop_front());
                    if ({b_ov, b_co, b_sum} !== e || lat !== exl)
                        begin failures++; $display("FAIL sweep64 beat=%0d got ov=%b co=%b sum=%h lat=%0d want ov=%b co=%b sum=%h lat=%0d", b_done, b_ov, b_co, b_sum, lat, e[65], e[64], e[63:0], exl); end
                end
                b_done++;
            end
            if (sw_in_valid && a_in_ready) begin
                qa.push_back(golden(16, sw_x, sw_y, sw_cin, sw_sub)); qa_acc.push_back(cyc); qa_st.push_back(a_stalls); a_acc++;
            end
            if (sw_in_valid && b_in_ready) begin
                qb.push_back(golden(64, sw_x, sw_y, sw_cin, sw_sub)); qb_acc.push_back(cyc); qb_st.push_back(b_stalls); b_acc++;
            end
            if (a_out_valid && !sw_out_ready) a_stalls++;
            if (b_out_valid && !sw_out_ready) b_stalls++;
            cyc++;
        end
        sw_in_valid = 1'b0;
        checks++;
        if (a_done < 10000 || b_done < 10000 || a_done !== a_acc || b_done !== b_acc)
            begin failures++; $display("FAIL sweep_count got a=%0d/%0d b=%0d/%0d want >=10000 and equal", a_done, a_acc, b_done, b_acc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0)
                begin failures++; $display("FAIL sweep_dup cyc=%0d got a=%b b=%b want 0 0", i, a_out_valid, b_out_valid); end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_random_single();
        test_back_pressure();
        test_reset_midstream();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
